// File: rtl/vrased_reset_seq.sv
// Violation-driven reset sequencer: latches VRASED monitor flags, stretches a CPU reset request,
// gates DMA until the CPU fetches from RESET_HANDLER. Optional counter: `VRASED_VIOL_CNT_EN.
module vrased_reset_seq #(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int unsigned HOLD_CYCLES   = 8,
  parameter int unsigned RECOVER_TMO   = 64,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             mclk,
  input  logic             por,
  input  logic [5:0]       viol,
  input  logic [15:0]      pc,
  input  logic             cause_clr,
  output logic             sys_rst_req,
  output logic             dma_block,
  output logic [5:0]       cause,
  output logic [5:0]       first_cause,
  output logic             busy,
  output logic [CNT_W-1:0] viol_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RECOVER = 2'd2,
    ST_BAD     = 2'd3
  } state_e;

  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] TMO_RELOAD  = 8'(RECOVER_TMO - 1);

  state_e     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic [5:0] first_cause_q, first_cause_d;
  logic [5:0] cause_q, cause_d;
  logic       sys_rst_req_q, sys_rst_req_d;
  logic       dma_block_q, dma_block_d;
  logic       busy_q, busy_d;
  logic       any_v;

  assign any_v = |viol;

  always_ff @(posedge mclk or posedge por) begin
    if (por) begin
      state_q       <= ST_IDLE;
      hold_cnt_q    <= 8'd0;
      tmo_cnt_q     <= 8'd0;
      first_cause_q <= 6'd0;
      cause_q       <= 6'd0;
      sys_rst_req_q <= 1'b0;
      dma_block_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      first_cause_q <= first_cause_d;
      cause_q       <= cause_d;
      sys_rst_req_q <= sys_rst_req_d;
      dma_block_q   <= dma_block_d;
      busy_q        <= busy_d;
    end
  end

  // A violation in any non-idle state restarts the hold window; only IDLE->HOLD records first_cause.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    first_cause_d = first_cause_q;
    case (state_q)
      ST_IDLE: begin
        if (any_v) begin
          state_d       = ST_HOLD;
          hold_cnt_d    = HOLD_RELOAD;
          first_cause_d = viol;
        end
      end
      ST_HOLD: begin
        if (any_v) begin
          hold_cnt_d = HOLD_RELOAD;
        end else if (hold_cnt_q == 8'd0) begin
          state_d   = ST_RECOVER;
          tmo_cnt_d = TMO_RELOAD;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      ST_RECOVER: begin
        if (any_v || (pc != RESET_HANDLER && tmo_cnt_q == 8'd0)) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_RELOAD;
        end else if (pc == RESET_HANDLER) begin
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = HOLD_RELOAD;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    sys_rst_req_d = (state_d == ST_HOLD);
    dma_block_d   = (state_d != ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    cause_d       = (cause_clr ? 6'd0 : cause_q) | viol;
  end

  assign sys_rst_req = sys_rst_req_q;
  assign dma_block   = dma_block_q;
  assign busy        = busy_q;
  assign cause       = cause_q;
  assign first_cause = first_cause_q;

`ifdef VRASED_VIOL_CNT_EN
  logic             any_v_q;
  logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;

  always_comb begin
    viol_cnt_d = viol_cnt_q;
    if (any_v && !any_v_q && (viol_cnt_q != {CNT_W{1'b1}})) begin
      viol_cnt_d = viol_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge mclk or posedge por) begin
    if (por) begin
      any_v_q    <= 1'b0;
      viol_cnt_q <= '0;
    end else begin
      any_v_q    <= any_v;
      viol_cnt_q <= viol_cnt_d;
    end
  end

  assign viol_cnt = viol_cnt_q;
`else
  assign viol_cnt = '0;
`endif

endmodule

// File: tb/tb_vrased_reset_seq.sv
// Directed + randomized bench for vrased_reset_seq against a cycle-count reference model.
module tb_vrased_reset_seq;

  localparam int HOLD = 8;
  localparam int TMO  = 64;
  localparam logic [15:0] RH = 16'h0000;

  logic        mclk = 1'b0;
  logic        por;
  logic [5:0]  viol;
  logic [15:0] pc;
  logic        cause_clr;
  logic        sys_rst_req, dma_block, busy;
  logic [5:0]  cause, first_cause;
  logic [7:0]  viol_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: remaining reset-request cycles and remaining recovery-wait cycles.
  int         m_hold_left, m_rec_left, m_cnt;
  logic       m_prev;
  logic [5:0] m_cause, m_first;

  vrased_reset_seq #(
    .RESET_HANDLER(RH), .HOLD_CYCLES(HOLD), .RECOVER_TMO(TMO), .CNT_W(8)
  ) dut (
    .mclk(mclk), .por(por), .viol(viol), .pc(pc), .cause_clr(cause_clr),
    .sys_rst_req(sys_rst_req), .dma_block(dma_block), .cause(cause),
    .first_cause(first_cause), .busy(busy), .viol_cnt(viol_cnt)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold_left = 0; m_rec_left = 0; m_cnt = 0;
    m_prev = 1'b0; m_cause = 6'd0; m_first = 6'd0;
  endtask

  task automatic model_edge(input logic [5:0] v, input logic [15:0] p, input logic c);
    logic any;
    any = |v;
    if (m_hold_left == 0 && m_rec_left == 0 && any) m_first = v;
    m_cause = (c ? 6'd0 : m_cause) | v;
    if (any && !m_prev && m_cnt < 255) m_cnt++;
    m_prev = any;
    if (any) begin
      m_hold_left = HOLD;
      m_rec_left  = 0;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_rec_left = TMO;
    end else if (m_rec_left > 0) begin
      if (p == RH) m_rec_left = 0;
      else if (m_rec_left == 1) begin
        m_rec_left  = 0;
        m_hold_left = HOLD;
      end else m_rec_left--;
    end
  endtask

  task automatic check_all();
    logic m_busy;
    m_busy = (m_hold_left > 0) || (m_rec_left > 0);
    chk("sys_rst_req", 32'(sys_rst_req), 32'(m_hold_left > 0));
    chk("dma_block", 32'(dma_block), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("cause", 32'(cause), 32'(m_cause));
    chk("first_cause", 32'(first_cause), 32'(m_first));
`ifdef VRASED_VIOL_CNT_EN
    chk("viol_cnt", 32'(viol_cnt), 32'(m_cnt));
`else
    chk("viol_cnt", 32'(viol_cnt), 32'd0);
`endif
  endtask

  task automatic step(input logic [5:0] v, input logic [15:0] p, input logic c);
    viol = v; pc = p; cause_clr = c;
    @(posedge mclk);
    model_edge(v, p, c);
    @(negedge mclk);
    check_all();
  endtask

  initial begin
    int n;
    logic [5:0] rv;
    logic [15:0] rp;
    por = 1'b1; viol = 6'd0; pc = 16'h1234; cause_clr = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge mclk);
    por = 1'b0;
    step(6'd0, 16'h1234, 1'b0);

    // Single-cycle violation: 8 cycles of reset request, then release on pc match.
    step(6'h02, 16'h1234, 1'b0);
    n = 0;
    for (int i = 0; i < 20 && sys_rst_req; i++) begin
      n++;
      step(6'd0, 16'h1234, 1'b0);
    end
    chk("hold_len", 32'(n), 32'd8);
    chk("first_02", 32'(first_cause), 32'h02);
    chk("cause_02", 32'(cause), 32'h02);
    step(6'd0, 16'h1234, 1'b0);
    step(6'd0, 16'h1234, 1'b0);
    step(6'd0, 16'h0000, 1'b0);
    chk("released_busy", 32'(busy), 32'd0);
    chk("released_dma", 32'(dma_block), 32'd0);

    // Extension by a second flag during hold.
    step(6'd0, 16'h1234, 1'b1);
    step(6'h01, 16'h1234, 1'b0);
    for (int i = 0; i < 4; i++) step(6'd0, 16'h1234, 1'b0);
    step(6'h20, 16'h1234, 1'b0);
    chk("cause_21", 32'(cause), 32'h21);
    chk("first_01", 32'(first_cause), 32'h01);
    n = 0;
    for (int i = 0; i < 20 && sys_rst_req; i++) begin
      n++;
      step(6'd0, 16'hE000, 1'b0);
    end
    chk("ext_len", 32'(n), 32'd8);

    // Recovery timeout with pc stuck away from the handler.
    n = 0;
    for (int i = 0; i < 100 && !sys_rst_req; i++) begin
      n++;
      step(6'd0, 16'hE000, 1'b0);
    end
    chk("tmo_len", 32'(n), 32'd64);
    chk("tmo_rehold", 32'(sys_rst_req), 32'd1);

    // Clear and set in the same cycle: set wins.
    step(6'h03, 16'hE000, 1'b1);
    step(6'h04, 16'hE000, 1'b1);
    chk("clr_set", 32'(cause), 32'h04);

    // Asynchronous power-on reset mid-hold.
    step(6'd0, 16'hE000, 1'b0);
    #2 por = 1'b1;
    #1;
    model_reset();
    chk("por_rst", 32'(sys_rst_req), 32'd0);
    chk("por_busy", 32'(busy), 32'd0);
    chk("por_dma", 32'(dma_block), 32'd0);
    chk("por_cause", 32'(cause), 32'd0);
    chk("por_first", 32'(first_cause), 32'd0);
    @(negedge mclk);
    por = 1'b0;
    step(6'd0, 16'hE000, 1'b0);
    chk("por_idle", 32'(busy), 32'd0);

    // Steady level counts once.
    for (int i = 0; i < 10; i++) step(6'h08, 16'h1234, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 11) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      rp = ($urandom_range(0, 15) == 0) ? RH : 16'($urandom);
      step(rv, rp, ($urandom_range(0, 19) == 0));
    end

    // Saturation of the event counter.
    for (int i = 0; i < 300; i++) begin
      step(6'($urandom_range(1, 63)), 16'h1234, 1'b0);
      step(6'd0, 16'h1234, 1'b0);
    end
`ifdef VRASED_VIOL_CNT_EN
    chk("cnt_sat", 32'(viol_cnt), 32'hFF);
`else
    chk("cnt_tied", 32'(viol_cnt), 32'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
